// File: rtl/tdes_mode_controller.sv
// tdes_mode_controller: ECB/CBC chaining and block handshake
// control wrapped around an iterative 3DES core.
module tdes_mode_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cbc_en,
  input  logic        decrypt,
  input  logic [63:0] iv,
  input  logic        iv_load,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        core_enable,
  output logic [2:0]  core_mode,
  output logic [63:0] core_data_in,
  input  logic        core_data_ready,
  input  logic [63:0] core_data_out,
  output logic        busy,
  output logic        err,
  input  logic        clear_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [63:0]      chain_q, chain_d;
  logic [63:0]      blk_q, blk_d;
  logic             cbc_q, cbc_d;
  logic             dec_q, dec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      out_q, out_d;
  logic             err_q, err_d;

  logic st_idle, st_launch, st_wait;
  logic st_hold, st_error;
  logic [63:0] result;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_launch = (state_q == ST_LAUNCH);
  assign st_wait   = (state_q == ST_WAIT);
  assign st_hold   = (state_q == ST_HOLD);
  assign st_error  = (state_q == ST_ERROR);

  assign in_ready    = st_idle && !iv_load;
  assign out_valid   = st_hold;
  assign out_data    = out_q;
  assign core_enable = st_launch;
  assign core_mode   = {2'b00, dec_q};
  assign busy        = !st_idle;
  assign err         = err_q;

  // Chain is only rewritten on leaving WAIT, so this stays
  // stable for the whole LAUNCH/WAIT window.
  assign core_data_in = (cbc_q && !dec_q) ?
                        (blk_q ^ chain_q) : blk_q;

  assign result = (cbc_q && dec_q) ?
                  (core_data_out ^ chain_q) : core_data_out;

  // Next-state: block sequencing, chaining and timeout.
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    blk_d   = blk_q;
    cbc_d   = cbc_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (1'b1)
      st_idle: begin
        if (iv_load) begin
          chain_d = iv;
        end else if (in_valid) begin
          blk_d   = in_data;
          cbc_d   = cbc_en;
          dec_d   = decrypt;
          state_d = ST_LAUNCH;
        end
      end
      st_launch: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      st_wait: begin
        if (core_data_ready) begin
          out_d = result;
          if (cbc_q) begin
            chain_d = dec_q ? blk_q : core_data_out;
          end
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      st_hold: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      st_error: begin
        if (clear_err) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      chain_q <= '0;
      blk_q   <= '0;
      cbc_q   <= 1'b0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      blk_q   <= blk_d;
      cbc_q   <= cbc_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tdes_mode_controller.sv
// tb_tdes_mode_controller: directed and randomized checks
// against a transaction-level model and a 3DES core stub.
module tb_tdes_mode_controller;

  localparam int TO = 255;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        n_rst;
  logic        cbc_en, decrypt;
  logic [63:0] iv;
  logic        iv_load;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        core_enable;
  logic [2:0]  core_mode;
  logic [63:0] core_data_in;
  logic        core_data_ready;
  logic [63:0] core_data_out;
  logic        busy, err, clear_err;

  int n_chk = 0;
  int n_fail = 0;
  int en_cnt = 0;

  int          stub_delay;
  logic        stub_mute, spur_en, noisy;
  logic        pend = 1'b0;
  int          left = 0;
  logic [63:0] res = '0;

  logic        e_idle, e_en, e_ov, e_err, e_mode, e_cinv;
  logic [63:0] e_cin, e_out, m_chain, m_blk;
  logic        m_cbc, m_dec;

  tdes_mode_controller #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .cbc_en(cbc_en),
    .decrypt(decrypt),
    .iv(iv),
    .iv_load(iv_load),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .core_enable(core_enable),
    .core_mode(core_mode),
    .core_data_in(core_data_in),
    .core_data_ready(core_data_ready),
    .core_data_out(core_data_out),
    .busy(busy),
    .err(err),
    .clear_err(clear_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk64(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic bound(input string nm, input logic ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got no event, expected one in budget",
               nm);
    end
  endtask

  // Core stub: inverts the block, answers stub_delay cycles
  // after the enable pulse; optional spurious ready pulses.
  initial begin
    core_data_ready = 1'b0;
    core_data_out   = '0;
    forever begin
      @(posedge clk);
      #1;
      core_data_ready = 1'b0;
      core_data_out   = rnd64();
      if (pend) begin
        left--;
        if (left == 0) begin
          core_data_ready = 1'b1;
          core_data_out   = res;
          pend            = 1'b0;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        core_data_ready = 1'b1;
      end
      if (core_enable && !stub_mute) begin
        pend = 1'b1;
        left = stub_delay;
        res  = core_data_in ^ ONES;
      end
    end
  end

  task automatic model_reset();
    e_idle  = 1'b1;
    e_en    = 1'b0;
    e_ov    = 1'b0;
    e_err   = 1'b0;
    e_mode  = 1'b0;
    e_cinv  = 1'b0;
    e_cin   = '0;
    e_out   = '0;
    m_chain = '0;
    m_blk   = '0;
    m_cbc   = 1'b0;
    m_dec   = 1'b0;
  endtask

  // Transaction-level model: one pass per block.
  task automatic model_run();
    logic done;
    forever begin
      e_idle = 1'b1;
      forever begin
        @(posedge clk);
        if (iv_load) m_chain = iv;
        else if (in_valid) break;
      end
      m_blk  = in_data;
      m_cbc  = cbc_en;
      m_dec  = decrypt;
      e_mode = decrypt;
      e_idle = 1'b0;
      e_en   = 1'b1;
      e_cinv = 1'b1;
      e_cin  = (m_cbc && !m_dec) ? (m_blk ^ m_chain) : m_blk;
      @(posedge clk);
      e_en = 1'b0;
      done = 1'b0;
      for (int k = 0; k <= TO; k++) begin
        @(posedge clk);
        if (core_data_ready) begin
          done = 1'b1;
          break;
        end
      end
      e_cinv = 1'b0;
      if (done) begin
        e_out = (m_cbc && m_dec) ?
                (core_data_out ^ m_chain) : core_data_out;
        if (m_cbc) m_chain = m_dec ? m_blk : core_data_out;
        e_ov = 1'b1;
        do @(posedge clk); while (!out_ready);
        e_ov = 1'b0;
      end else begin
        e_err = 1'b1;
        do @(posedge clk); while (!clear_err);
        e_err = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      model_reset();
      wait (n_rst === 1'b1);
      fork
        model_run();
        @(negedge n_rst);
      join_any
      disable fork;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk1("in_ready", in_ready, e_idle && !iv_load);
      chk1("busy", busy, !e_idle);
      chk1("out_valid", out_valid, e_ov);
      chk1("err", err, e_err);
      chk1("core_enable", core_enable, e_en);
      chk64("core_mode", 64'(core_mode), 64'({2'b00, e_mode}));
      chk64("out_data", out_data, e_out);
      if (e_cinv) chk64("core_data_in", core_data_in, e_cin);
      if (core_enable) en_cnt++;
    end
  end

  task automatic noise();
    if (noisy) begin
      iv_load   = ($urandom_range(0, 3) == 0);
      iv        = rnd64();
      clear_err = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic load_iv(input logic [63:0] v);
    @(negedge clk);
    iv_load = 1'b1;
    iv      = v;
    @(negedge clk);
    iv_load = 1'b0;
  endtask

  task automatic send(input logic [63:0] d,
                      input logic c, input logic dc);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    cbc_en    = c;
    decrypt   = dc;
    iv_load   = 1'b0;
    clear_err = 1'b0;
    #1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    bound("accept", n < 50);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rnd64();
    cbc_en   = 1'($urandom_range(0, 1));
    decrypt  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 600) begin
      noise();
      @(negedge clk);
      lat++;
    end
    bound("out_valid_wait", lat < 600);
  endtask

  task automatic wait_err(output int n);
    n = 1;
    while (err !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    bound("err_wait", n < 600);
  endtask

  task automatic take(input int stall);
    for (int s = 0; s < stall; s++) begin
      noise();
      @(negedge clk);
    end
    out_ready = 1'b1;
    iv_load   = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int e0;
    n_rst      = 1'b1;
    cbc_en     = 1'b0;
    decrypt    = 1'b0;
    iv         = '0;
    iv_load    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    clear_err  = 1'b0;
    stub_delay = 5;
    stub_mute  = 1'b0;
    spur_en    = 1'b0;
    noisy      = 1'b0;
    #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_core_enable", core_enable, 1'b0);
    chk64("rst_core_mode", 64'(core_mode), 64'd0);
    chk64("rst_out_data", out_data, 64'd0);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #3 n_rst = 1'b1;

    e0 = en_cnt;
    send(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    wait_out(lat);
    chk64("ecb_latency", 64'(lat), 64'd7);
    chk64("ecb_enc", out_data, 64'hFEDC_BA98_7654_3210);
    chk64("ecb_enable_pulses", 64'(en_cnt - e0), 64'd1);
    take(0);

    load_iv(64'h1);
    send(64'h0, 1'b1, 1'b0);
    wait_out(lat);
    chk64("cbc_enc_0", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
    take(0);
    send(64'h0, 1'b1, 1'b0);
    wait_out(lat);
    chk64("cbc_enc_1", out_data, 64'h0000_0000_0000_0001);
    take(1);

    load_iv(64'h1);
    send(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
    wait_out(lat);
    chk64("cbc_dec_0", out_data, 64'h0);
    take(0);
    send(64'h0000_0000_0000_0001, 1'b1, 1'b1);
    wait_out(lat);
    chk64("cbc_dec_1", out_data, 64'h0);
    take(2);

    send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1);
    wait_out(lat);
    chk64("dec_mode", 64'(core_mode), 64'd1);
    repeat (10) begin
      #1;
      chk1("stall_valid", out_valid, 1'b1);
      chk64("stall_data", out_data, 64'h5555_5555_5555_5555);
      chk1("stall_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    take(0);

    stub_delay = TO + 1;
    send(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    wait_out(lat);
    chk64("edge_latency", 64'(lat), 64'(TO + 3));
    chk64("edge_data", out_data, 64'hF0F0_F0F0_F0F0_F0F0);
    chk1("edge_no_err", err, 1'b0);
    take(0);

    stub_delay = TO + 2;
    send(64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0);
    wait_err(lat);
    chk64("timeout_cycles", 64'(lat), 64'(TO + 3));
    chk1("timeout_busy", busy, 1'b1);
    repeat (5) @(negedge clk);
    chk1("late_reply_ignored", out_valid, 1'b0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;

    stub_mute = 1'b1;
    send(64'h0, 1'b0, 1'b0);
    wait_err(lat);
    chk1("mute_err", err, 1'b1);
    chk1("mute_busy", busy, 1'b1);
    @(negedge clk);
    clear_err = 1'b1;
    iv_load   = 1'b1;
    iv        = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    clear_err = 1'b0;
    iv_load   = 1'b1;
    iv        = 64'h1234_5678_9ABC_DEF0;
    in_valid  = 1'b1;
    in_data   = 64'h0;
    cbc_en    = 1'b1;
    decrypt   = 1'b0;
    #1;
    chk1("ivload_blocks_ready", in_ready, 1'b0);
    chk1("cleared_err", err, 1'b0);
    stub_mute  = 1'b0;
    stub_delay = 5;
    send(64'h0, 1'b1, 1'b0);
    wait_out(lat);
    chk64("chain_from_iv", out_data, 64'hEDCB_A987_6543_210F);
    take(0);

    send(64'h1111_2222_3333_4444, 1'b0, 1'b1);
    @(negedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_err", err, 1'b0);
    chk1("abort_core_enable", core_enable, 1'b0);
    chk64("abort_core_mode", 64'(core_mode), 64'd0);
    chk64("abort_out_data", out_data, 64'd0);
    chk1("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #3 n_rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      chk1("abort_no_output", out_valid, 1'b0);
    end

    noisy   = 1'b1;
    spur_en = 1'b1;
    for (int b = 0; b < 60; b++) begin
      stub_delay = $urandom_range(1, 8);
      if ($urandom_range(0, 2) == 0) load_iv(rnd64());
      send(rnd64(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      wait_out(lat);
      take($urandom_range(0, 3));
    end
    noisy     = 1'b0;
    spur_en   = 1'b0;
    iv_load   = 1'b0;
    clear_err = 1'b0;
    repeat (20) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
